// File: rtl/mdu_sched_if.sv
// Port bundle between the E-stage datapath and the multiply/divide scheduler.
// The master side issues operations; the slave side (the scheduler) reports busy, stall and HI/LO.
interface mdu_sched_if;
    logic        req;
    logic        E_start;
    logic [3:0]  E_mdop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_is_md;
    logic        E_busy;
    logic        D_md_stall;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic        dbg_state;

    // Issue handshake: an op is taken on the edge where E_start is high, req is low,
    // E_busy is low and E_mdop is 1..6; the issuer must never raise E_start while E_busy.
    modport master (
        output req, E_start, E_mdop, E_A, E_B, D_is_md,
        input  E_busy, D_md_stall, E_HI, E_LO, dbg_state
    );

    modport slave (
        input  req, E_start, E_mdop, E_A, E_B, D_is_md,
        output E_busy, D_md_stall, E_HI, E_LO, dbg_state
    );
endinterface

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide scheduler with the architectural HI/LO pair.
// Results are computed at issue into a shadow pair and committed after a fixed busy window.
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  bus
);

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(MAX_N + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] sh_hi_q, sh_hi_d;
    logic [31:0] sh_lo_q, sh_lo_d;
    logic        commit_q, commit_d;

    logic        op_is_md;
    logic        op_valid;
    logic        busy;
    logic        go;

    assign op_is_md = (bus.E_mdop >= OP_MULT) && (bus.E_mdop <= OP_DIVU);
    assign op_valid = (bus.E_mdop >= OP_MULT) && (bus.E_mdop <= OP_MTLO);
    assign busy     = (state_q == S_BUSY);
    assign go       = bus.E_start && !bus.req && !busy && op_valid;

    // Products: the signed form relies on sign extension into the 64-bit context.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed(bus.E_A) * $signed(bus.E_B);
    assign prod_u = {32'd0, bus.E_A} * {32'd0, bus.E_B};

    // Division runs on magnitudes so 0x80000000 / -1 never overflows a signed divide.
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] div_num, div_den;
    logic [31:0] q_u, r_u;
    logic [31:0] quot, rem;
    logic        div_by_zero;

    always_comb begin
        div_signed  = (bus.E_mdop == OP_DIV);
        a_neg       = div_signed && bus.E_A[31];
        b_neg       = div_signed && bus.E_B[31];
        a_mag       = a_neg ? (32'd0 - bus.E_A) : bus.E_A;
        b_mag       = b_neg ? (32'd0 - bus.E_B) : bus.E_B;
        div_by_zero = (bus.E_B == 32'd0);
        div_num     = a_mag;
        div_den     = div_by_zero ? 32'd1 : b_mag;
        q_u         = div_num / div_den;
        r_u         = div_num % div_den;
        quot        = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
        rem         = a_neg ? (32'd0 - r_u) : r_u;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sh_hi_d  = sh_hi_q;
        sh_lo_d  = sh_lo_q;
        commit_d = commit_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    case (bus.E_mdop)
                        OP_MULT: begin
                            sh_hi_d  = prod_s[63:32];
                            sh_lo_d  = prod_s[31:0];
                            commit_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = S_BUSY;
                        end
                        OP_MULTU: begin
                            sh_hi_d  = prod_u[63:32];
                            sh_lo_d  = prod_u[31:0];
                            commit_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            sh_hi_d  = rem;
                            sh_lo_d  = quot;
                            // A zero divisor still burns the full window but leaves HI/LO alone.
                            commit_d = !div_by_zero;
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = S_BUSY;
                        end
                        OP_MTHI: hi_d = bus.E_A;
                        OP_MTLO: lo_d = bus.E_A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (commit_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sh_hi_q  <= '0;
            sh_lo_q  <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sh_hi_q  <= sh_hi_d;
            sh_lo_q  <= sh_lo_d;
            commit_q <= commit_d;
        end
    end

    // The stall deliberately ignores req so a squashed issue cycle stays conservative.
    assign bus.D_md_stall = bus.D_is_md && (busy || (bus.E_start && op_is_md));
    assign bus.E_busy     = busy;
    assign bus.E_HI       = hi_q;
    assign bus.E_LO       = lo_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: spec vectors from a table, seeded random ops, and
// hand sequences for squash, req-while-busy and reset-mid-operation.
module tb_mdu_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];
  logic [63:0] cur;

  mdu_sched_if bus ();

  mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          req_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Issuing while busy is a protocol error on the bench side.
  always @(posedge clk) begin
    if (!reset && bus.E_start) begin
      checks++;
      if (bus.E_busy) begin
        errors++;
        $display("FAIL protocol E_start while busy at %0t", $time);
      end
    end
  end

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] prev);
    longint sa, sb, q, m;
    logic [63:0] r;
    r = prev;
    case (op)
      4'd1: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      4'd2: r = {32'd0, a} * {32'd0, b};
      4'd3: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        m  = sa % sb;
        r  = {m[31:0], q[31:0]};
      end
      4'd4: if (b != 0) r = {a % b, a / b};
      4'd5: r = {a, prev[31:0]};
      4'd6: r = {prev[63:32], a};
      default: r = prev;
    endcase
    return r;
  endfunction

  // driver: issue one op at a negedge, follow the busy window, then score the commit
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv, input bit req_busy);
    int n;
    int exp_n;
    logic [63:0] want;
    exp_n = (op == 4'd1 || op == 4'd2) ? MULT_N : ((op == 4'd3 || op == 4'd4) ? DIV_N : 0);
    exp_q.push_back(expv);
    bus.E_start = 1'b1;
    bus.E_mdop  = op;
    bus.E_A     = a;
    bus.E_B     = b;
    #1;
    chk("stall_issue", {63'd0, bus.D_md_stall}, {63'd0, (exp_n != 0)});
    @(negedge clk);
    bus.E_start = 1'b0;
    bus.E_mdop  = 4'd0;
    if (req_busy) bus.req = 1'b1;
    n = 0;
    while (bus.E_busy && n < 100) begin
      n++;
      chk("stall_busy", {63'd0, bus.D_md_stall}, 64'd1);
      chk("hilo_hold", {bus.E_HI, bus.E_LO}, cur);
      @(negedge clk);
    end
    bus.req = 1'b0;
    chk("busy_len", 64'(n), 64'(exp_n));
    chk("stall_after", {63'd0, bus.D_md_stall}, 64'd0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 expected 1");
    end else begin
      want = exp_q.pop_front();
      chk("hilo_commit", {bus.E_HI, bus.E_LO}, want);
      cur = want;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur    = 64'd0;
    reset  = 1'b1;
    bus.req = 1'b0; bus.E_start = 1'b0; bus.E_mdop = 4'd0;
    bus.E_A = 32'd0; bus.E_B = 32'd0; bus.D_is_md = 1'b1;

    vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{4'd4, 32'd7,        32'd2,        1'b0, 32'd1,        32'd3};
    vecs[3] = '{4'd3, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000};
    vecs[5] = '{4'd5, 32'h11,       32'd0,        1'b0, 32'h11,       32'h80000000};
    vecs[6] = '{4'd6, 32'h22,       32'd0,        1'b0, 32'h11,       32'h22};
    vecs[7] = '{4'd3, 32'd9,        32'd0,        1'b0, 32'h11,       32'h22};
    vecs[8] = '{4'd4, 32'd9,        32'd0,        1'b1, 32'h11,       32'h22};
    vecs[9] = '{4'd1, 32'd7,        32'hFFFFFFFE, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF2};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {63'd0, bus.E_busy}, 64'd0);
    chk("reset_hilo", {bus.E_HI, bus.E_LO}, 64'd0);
    chk("reset_stall", {63'd0, bus.D_md_stall}, 64'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo}, vecs[i].req_busy);

    // squashed mthi and mult: nothing may change
    bus.req = 1'b1; bus.E_start = 1'b1; bus.E_mdop = 4'd5; bus.E_A = 32'h1234;
    #1;
    chk("squash_mthi_stall", {63'd0, bus.D_md_stall}, 64'd0);
    @(negedge clk);
    bus.E_mdop = 4'd1; bus.E_A = 32'd3; bus.E_B = 32'd3;
    chk("squash_mthi_hilo", {bus.E_HI, bus.E_LO}, cur);
    #1;
    chk("squash_mult_stall", {63'd0, bus.D_md_stall}, 64'd1);
    @(negedge clk);
    bus.req = 1'b0; bus.E_start = 1'b0; bus.E_mdop = 4'd0;
    chk("squash_mult_busy", {63'd0, bus.E_busy}, 64'd0);
    chk("squash_mult_hilo", {bus.E_HI, bus.E_LO}, cur);

    // reset in the third busy cycle of a divide discards it
    bus.E_start = 1'b1; bus.E_mdop = 4'd4; bus.E_A = 32'd100; bus.E_B = 32'd7;
    @(negedge clk);
    bus.E_start = 1'b0; bus.E_mdop = 4'd0;
    chk("rst_mid_busy_before", {63'd0, bus.E_busy}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cur = 64'd0;
    chk("rst_mid_busy", {63'd0, bus.E_busy}, 64'd0);
    chk("rst_mid_hilo", {bus.E_HI, bus.E_LO}, 64'd0);
    repeat (15) @(negedge clk);
    chk("rst_no_commit_busy", {63'd0, bus.E_busy}, 64'd0);
    chk("rst_no_commit_hilo", {bus.E_HI, bus.E_LO}, 64'd0);

    // seeded random ops scored against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 6));
      a  = $urandom();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom());
      if ($urandom_range(0, 1) == 0) a = 32'(int'($urandom_range(0, 200)) - 100);
      do_op(op, a, b, ref_result(op, a, b, cur), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
